// File: rtl/reg_share_pkg.sv
// Shared types and helpers for the register-sharing arbiter.
// Holds the FSM encoding, hold counter width and one-hot helper.
package reg_share_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int HOLD_W = 4;

  function automatic logic [7:0] onehot(
    input logic [2:0] idx,
    input int         n
  );
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < n && idx == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit
// at or after start, wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [IW-1:0]   win,
  output logic            found
);

  int idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner of one shared data register with
// bounded write bursts and zero-bubble handoff.
module reg_share_arbiter
  import reg_share_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int NREQ      = 4,
  parameter int MAX_HOLD  = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] d,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           wr_ack,
  output logic [DATAWIDTH-1:0]      q,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);

  state_t            state;
  logic [IW-1:0]     last;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic [IW-1:0]     start;
  logic [IW-1:0]     win;
  logic              found;
  logic              wr;
  logic              rel;
  logic [NREQ-1:0]   win_oh;
  logic [NREQ-1:0]   own_oh;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // A releasing owner is searched last, same as an idle restart.
  always_comb begin
    start    = (state == IDLE) ? nxt(last) : nxt(owner);
    wr       = (state == OWN) && req[owner];
    hold_nxt = hold_cnt + 1'b1;
    rel      = (state == OWN) &&
               (!wr || hold_nxt == HOLD_W'(MAX_HOLD));
    win_oh   = NREQ'(onehot(3'(win), NREQ));
    own_oh   = NREQ'(onehot(3'(owner), NREQ));
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req),
    .start (start),
    .win   (win),
    .found (found)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      gnt      <= '0;
      wr_ack   <= '0;
      q        <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      last     <= IW'(NREQ - 1);
      hold_cnt <= '0;
    end else begin
      wr_ack <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            state    <= OWN;
            gnt      <= win_oh;
            owner    <= win;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end
        end
        OWN: begin
          if (wr) begin
            q        <= d[int'(owner)*DATAWIDTH +: DATAWIDTH];
            wr_ack   <= own_oh;
            hold_cnt <= hold_nxt;
          end
          if (rel) begin
            last <= owner;
            if (found) begin
              gnt      <= win_oh;
              owner    <= win;
              hold_cnt <= '0;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter (NREQ=4, MAX_HOLD=4).
module tb_reg_share_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;

  logic            Clk;
  logic            Rst;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] d;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   wr_ack;
  logic [DW-1:0]   q;
  logic [1:0]      owner;
  logic            busy;

  int ncmp = 0;
  int nerr = 0;
  int ackcnt [NR];

  reg_share_arbiter #(
    .DATAWIDTH (DW),
    .NREQ      (NR),
    .MAX_HOLD  (4)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .req    (req),
    .d      (d),
    .gnt    (gnt),
    .wr_ack (wr_ack),
    .q      (q),
    .owner  (owner),
    .busy   (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [NR-1:0] oh(input int i);
    return NR'(1) << i;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic setd(input int i, input logic [DW-1:0] v);
    d[i*DW +: DW] = v;
  endtask

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst = 1'b1;
    req = '0;
    d   = '0;
    foreach (ackcnt[i]) ackcnt[i] = 0;
    #1 Rst = 1'b0;
    #1;
    chk("rst_q", q, 0);
    chk("rst_gnt", 64'(gnt), 0);
    chk("rst_ack", 64'(wr_ack), 0);
    chk("rst_owner", 64'(owner), 0);
    chk("rst_busy", 64'(busy), 0);
    #1 Rst = 1'b1;
    tick();

    // single burst by requester 2
    req = 4'b0100;
    setd(2, 64'h11);
    tick();
    chk("sb_gnt", 64'(gnt), 64'(4'b0100));
    chk("sb_owner", 64'(owner), 2);
    chk("sb_busy", 64'(busy), 1);
    chk("sb_noack", 64'(wr_ack), 0);
    tick();
    chk("sb_q1", q, 64'h11);
    chk("sb_ack1", 64'(wr_ack), 64'(4'b0100));
    setd(2, 64'h22);
    tick();
    chk("sb_q2", q, 64'h22);
    chk("sb_ack2", 64'(wr_ack), 64'(4'b0100));
    req = '0;
    tick();
    chk("sb_idle_gnt", 64'(gnt), 0);
    chk("sb_idle_busy", 64'(busy), 0);
    chk("sb_idle_ack", 64'(wr_ack), 0);
    chk("sb_idle_q", q, 64'h22);
    chk("sb_idle_owner", 64'(owner), 2);

    // burst limit: req0 and req1 both pending
    req = 4'b0011;
    setd(1, 64'hB1);
    tick();
    chk("mh_gnt0", 64'(gnt), 64'(4'b0001));
    for (int k = 1; k <= 4; k++) begin
      setd(0, 64'hA0 + 64'(k));
      tick();
      chk("mh_ack", 64'(wr_ack), 64'(4'b0001));
      chk("mh_q", q, 64'hA0 + 64'(k));
      chk("mh_gnt", 64'(gnt), (k == 4) ? 64'(4'b0010) : 64'(4'b0001));
    end
    chk("mh_busy", 64'(busy), 1);
    req = 4'b0010;
    tick();
    chk("mh_ack1", 64'(wr_ack), 64'(4'b0010));
    chk("mh_q1", q, 64'hB1);
    req = '0;
    tick();
    chk("mh_idle", 64'(gnt), 0);

    // asynchronous reset mid-burst
    req = 4'b0001;
    setd(0, 64'hDEAD);
    tick();
    chk("ar_gnt", 64'(gnt), 64'(4'b0001));
    tick();
    chk("ar_q", q, 64'hDEAD);
    #3 Rst = 1'b0;
    #1;
    chk("ar_q0", q, 0);
    chk("ar_gnt0", 64'(gnt), 0);
    chk("ar_busy0", 64'(busy), 0);
    chk("ar_ack0", 64'(wr_ack), 0);
    #1;
    Rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NR; i++) setd(i, 64'h100 + 64'(i));
    tick();
    chk("ar_regnt", 64'(gnt), 64'(4'b0001));

    // round robin across all requesters
    for (int r = 0; r < NR; r++) begin
      for (int k = 1; k <= 4; k++) begin
        tick();
        for (int i = 0; i < NR; i++) ackcnt[i] += int'(wr_ack[i]);
        chk("rr_ack", 64'(wr_ack), 64'(oh(r)));
        chk("rr_q", q, 64'h100 + 64'(r));
        chk("rr_gnt", 64'(gnt),
            (k == 4) ? 64'(oh((r + 1) % NR)) : 64'(oh(r)));
      end
    end
    for (int i = 0; i < NR; i++) chk("rr_cnt", 64'(ackcnt[i]), 4);

    // lone persistent requester 3
    req = 4'b1000;
    tick();
    chk("lp_gnt", 64'(gnt), 64'(4'b1000));
    chk("lp_noack", 64'(wr_ack), 0);
    for (int i = 0; i < 12; i++) begin
      setd(3, 64'h300 + 64'(i));
      tick();
      chk("lp_ack", 64'(wr_ack), 64'(4'b1000));
      chk("lp_q", q, 64'h300 + 64'(i));
      chk("lp_gnt", 64'(gnt), 64'(4'b1000));
    end

    // non-owner isolation
    req = 4'b0010;
    setd(1, 64'h55);
    tick();
    chk("ni_gnt", 64'(gnt), 64'(4'b0010));
    chk("ni_noack", 64'(wr_ack), 0);
    tick();
    chk("ni_q1", q, 64'h55);
    req = 4'b0110;
    setd(2, 64'hFF);
    tick();
    chk("ni_q2", q, 64'h55);
    chk("ni_ack2", 64'(wr_ack), 64'(4'b0010));
    req = 4'b0010;
    tick();
    chk("ni_q3", q, 64'h55);
    chk("ni_ack3", 64'(wr_ack), 64'(4'b0010));
    req = '0;
    tick();
    chk("ni_gnt0", 64'(gnt), 0);
    chk("ni_busy0", 64'(busy), 0);
    chk("ni_owner", 64'(owner), 1);
    chk("ni_qhold", q, 64'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
